// File: rtl/jh_sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_REQ requesters, with a tagged read-return pipeline.
// Optional write priority: define JH_SRAM_ARB_WR_PRIO_EN to restrict arbitration to writers whenever any writer is requesting.
module jh_sram_port_arbiter #(
   parameter  int DATA_WIDTH     = 8,
   parameter  int REQ_ADDR_WIDTH = 8,
   parameter  int NUM_REQ        = 2,
   parameter  int RD_LATENCY     = 1,
   localparam int IDX_W          = $clog2(NUM_REQ),
   localparam int MEM_ADDR_WIDTH = IDX_W + REQ_ADDR_WIDTH
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            clear,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ-1:0]              req_we,
   input  logic [NUM_REQ*REQ_ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]              gnt,
   output logic [NUM_REQ-1:0]              rvalid,
   output logic [DATA_WIDTH-1:0]           rdata,
   output logic [MEM_ADDR_WIDTH-1:0]       mem_addr,
   output logic [DATA_WIDTH-1:0]           mem_din,
   output logic                            mem_wr_enable,
   output logic                            mem_rd_enable,
   input  logic [DATA_WIDTH-1:0]           mem_dout
);

   logic [REQ_ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
   logic [DATA_WIDTH-1:0]     wdata_a [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_a[i]  = req_addr[i*REQ_ADDR_WIDTH +: REQ_ADDR_WIDTH];
      assign wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
   end

   logic [IDX_W-1:0]   last_r;
   logic [NUM_REQ-1:0] elig;
   logic [IDX_W-1:0]   cand;
   logic [IDX_W-1:0]   win_idx;
   logic               win_vld;
   logic               fire;
   logic               rd_fire;

   // Candidate search from last_r+1 upward; NUM_REQ is a power of two so IDX_W-bit addition wraps.
   always_comb begin
`ifdef JH_SRAM_ARB_WR_PRIO_EN
      elig = (|(req & req_we)) ? (req & req_we) : req;
`else
      elig = req;
`endif
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      // Walk from lowest to highest priority so the last hit is the highest-priority requester.
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = last_r + IDX_W'(k);
         if (elig[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   assign fire    = win_vld & ~clear & rstn;
   assign rd_fire = fire & ~req_we[win_idx];

   always_comb begin
      gnt           = '0;
      mem_addr      = '0;
      mem_din       = '0;
      mem_wr_enable = 1'b0;
      mem_rd_enable = 1'b0;
      if (fire) begin
         gnt[win_idx]  = 1'b1;
         mem_addr      = {win_idx, addr_a[win_idx]};
         mem_din       = wdata_a[win_idx];
         mem_wr_enable = req_we[win_idx];
         mem_rd_enable = ~req_we[win_idx];
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)      last_r <= IDX_W'(NUM_REQ - 1);
      else if (clear) last_r <= IDX_W'(NUM_REQ - 1);
      else if (fire)  last_r <= win_idx;
   end

   logic [RD_LATENCY-1:0] vld_r;
   logic [IDX_W-1:0]      tag_r [RD_LATENCY];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_r <= '0;
      end else if (clear) begin
         vld_r <= '0;
      end else begin
         vld_r[0] <= rd_fire;
         for (int s = 1; s < RD_LATENCY; s++) vld_r[s] <= vld_r[s-1];
      end
   end

   // NOTE: tags are left unreset; they are only observed when the matching valid bit is set.
   always_ff @(posedge clk) begin
      tag_r[0] <= win_idx;
      for (int s = 1; s < RD_LATENCY; s++) tag_r[s] <= tag_r[s-1];
   end

   always_comb begin
      rvalid = '0;
      if (vld_r[RD_LATENCY-1] & ~clear & rstn) rvalid[tag_r[RD_LATENCY-1]] = 1'b1;
   end

   assign rdata = mem_dout;

endmodule

// File: doc/jh_sram_port_arbiter.md
# jh_sram_port_arbiter

Round-robin arbiter that shares one external single-port SRAM among NUM_REQ requesters, typically the memory ports of several external-SRAM sync FIFOs placed on one macro. Each requester owns a private address window selected by its index. The block grants at most one access per cycle and drives the SRAM pins. It returns read data with a fixed, tagged latency so each requester sees its own read-valid strobe.

## Interface
- DATA_WIDTH, 8, data width of requester and SRAM data.
- REQ_ADDR_WIDTH, 8, per-requester address width (window size 2^REQ_ADDR_WIDTH).
- NUM_REQ, 2, number of requesters; power of two, 2..8.
- RD_LATENCY, 1, SRAM clock-to-read-data latency in cycles, 1..3.
- Derived: IDX_W = $clog2(NUM_REQ); MEM_ADDR_WIDTH = IDX_W + REQ_ADDR_WIDTH.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush.
- req  in  NUM_REQ  access request per requester.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*REQ_ADDR_WIDTH  packed addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- gnt  out  NUM_REQ  one-hot grant, same cycle as the request.
- rvalid  out  NUM_REQ  read data valid for requester i.
- rdata  out  DATA_WIDTH  shared read data; qualified by rvalid.
- mem_addr  out  MEM_ADDR_WIDTH  SRAM address = {i, req_addr[i]}.
- mem_din  out  DATA_WIDTH  SRAM write data.
- mem_wr_enable  out  1  SRAM write strobe.
- mem_rd_enable  out  1  SRAM read strobe.
- mem_dout  in  DATA_WIDTH  SRAM read data.

## Operation
- Transfer occurs on req[i] & gnt[i]. A requester holds req, req_we, addr and wdata stable until it is granted.
- gnt is combinational from req and the pointer last_r. The search starts at last_r+1 mod NUM_REQ and picks the first asserted req.
- last_r updates to the granted index on each grant. It holds when there is no grant.
- On a grant: mem_addr = {idx, req_addr[idx]}, mem_din = req_wdata[idx], mem_wr_enable = req_we[idx], mem_rd_enable = ~req_we[idx].
- Idle cycle (no req): gnt = 0, mem_addr = 0, mem_din = 0, both enables 0.
- Read return pipeline: RD_LATENCY stages, each holding a valid bit and an IDX_W tag. Stage 0 loads on a granted read.
- rvalid[tag] = last-stage valid. rdata = mem_dout, passed through combinationally.
- Reads and writes are never merged. Write-then-read to the same address in consecutive cycles returns the new data.
- clear: gnt forced 0 and enables 0 in that cycle. The pipeline valid bits are zeroed, so in-flight reads are dropped. last_r <= NUM_REQ-1.

## Timing
- Reset values: last_r = NUM_REQ-1, so requester 0 wins first. All pipeline valid bits = 0.
- While rstn is low, or while clear is high: gnt = 0, rvalid = 0, both mem enables = 0.
- Grant latency is 0 cycles and back-to-back grants are allowed.
- A single continuous requester is granted every cycle.
- Read data latency: rvalid asserts exactly RD_LATENCY cycles after the grant cycle.
- Worst-case wait for a requester is NUM_REQ-1 cycles.
- Reset asserted mid-read: the pending rvalid never appears.

## Configuration
- JH_SRAM_ARB_WR_PRIO_EN defined: if any req[i] & req_we[i] is set, the round-robin search considers only write requesters. last_r still updates to the winner. This prevents upstream FIFOs from stalling on full.
- Not defined: pure round-robin over all requesters, regardless of req_we.

## Test plan
- Reset release with req = 0 → gnt = 0, rvalid = 0, mem_wr_enable = 0, mem_rd_enable = 0, mem_addr = 0.
- NUM_REQ=2; req0 and req1 continuously read addr 0x05 / 0x07 → gnt = 01,10,01,10…; mem_addr = 0x005, 0x107 alternating; rvalid[0] and rvalid[1] alternate with the matching mem_dout RD_LATENCY cycles later.
- Only req1 active, 4 reads → gnt[1] = 1 for 4 consecutive cycles with no bubble; 4 rvalid[1] pulses.
- req1 writes 0xA5 to 0x10, then reads 0x10 the next cycle (RD_LATENCY=1) → mem_wr_enable pulse at address 0x110; rvalid[1] with rdata = 0xA5 one cycle after the read grant.
- RD_LATENCY=2; clear asserted the cycle after req0's read grant → no rvalid; next simultaneous req0/req1 grants req0.
- last_r = 0; req0 read and req1 write at the same time → with JH_SRAM_ARB_WR_PRIO_EN req1 is granted; without the macro req1 is also granted (round-robin). Then, with last_r = 1 → with the macro req1 is granted again; without it req0 is granted.
